// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and helpers for the param_sync_fifo slice.
// Read mode is chosen by the compile-time macro PARAM_SYNC_FIFO_FWFT_EN.
package param_sync_fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy spans 0..DEPTH inclusive, hence one bit wider than a pointer.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int DEF_CNT_W = cnt_w(DEF_DEPTH);

   typedef enum logic {
      RD_REGISTERED = 1'b0,
      RD_FWFT       = 1'b1
   } rd_mode_e;

`ifdef PARAM_SYNC_FIFO_FWFT_EN
   localparam rd_mode_e RD_MODE = RD_FWFT;
`else
   localparam rd_mode_e RD_MODE = RD_REGISTERED;
`endif

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Simple dual-port storage for param_sync_fifo: synchronous write, read port
// registered or combinational (FWFT, macro PARAM_SYNC_FIFO_FWFT_EN).
module fifo_ram
   import param_sync_fifo_pkg::*;
#(
   parameter int       WIDTH = DEF_WIDTH,
   parameter int       DEPTH = DEF_DEPTH,
   parameter rd_mode_e MODE  = RD_MODE,
   localparam int      AW    = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   // Contents are never reset; occupancy lives in the controller.
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   generate
      if (MODE == RD_FWFT) begin : g_comb_rd
         logic w_unused;
         assign w_unused = &{1'b0, rst, rd_en};
         assign rd_data  = r_mem[rd_addr];
      end else begin : g_reg_rd
         logic [WIDTH-1:0] r_rd_data;
         // Same-address write and read return the old word (read-before-write).
         always_ff @(posedge clk) begin
            if (rst)        r_rd_data <= '0;
            else if (rd_en) r_rd_data <= r_mem[rd_addr];
         end
         assign rd_data = r_rd_data;
      end
   endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with registered flags, occupancy count and sticky errors.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module param_sync_fifo
   import param_sync_fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     almost_full,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count, w_count_nxt;
   logic             r_full, r_afull, r_empty, r_aempty;
   logic             r_ovf, r_unf;
   logic             w_wa, w_ra;
   logic [WIDTH-1:0] w_ram_rd_data;

   // A read at full frees the slot the simultaneous write lands in.
   assign w_ra = rd_en && !r_empty;
   assign w_wa = wr_en && (!r_full || w_ra);

   always_comb begin
      w_count_nxt = r_count;
      if (w_wa && !w_ra)      w_count_nxt = r_count + CW'(1);
      else if (w_ra && !w_wa) w_count_nxt = r_count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wa) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_ra) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == CW'(DEPTH));
         r_afull  <= (w_count_nxt >= CW'(AFULL_TH));
         r_empty  <= (w_count_nxt == '0);
         r_aempty <= (w_count_nxt <= CW'(AEMPTY_TH));
         r_ovf    <= r_ovf | (wr_en && !w_wa);
         r_unf    <= r_unf | (rd_en && r_empty);
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .MODE  (RD_MODE)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wa && !rst),
      .wr_addr (r_wr_ptr),
      .wr_data (wr_data),
      .rd_en   (w_ra),
      .rd_addr (r_rd_ptr),
      .rd_data (w_ram_rd_data)
   );

   generate
      if (RD_MODE == RD_FWFT) begin : g_fwft
         // Mask the head while empty so stale storage never shows on rd_data.
         assign rd_data  = r_empty ? '0 : w_ram_rd_data;
         assign rd_valid = !r_empty;
      end else begin : g_std
         logic r_rd_valid;
         always_ff @(posedge clk) begin
            if (rst) r_rd_valid <= 1'b0;
            else     r_rd_valid <= w_ra;
         end
         assign rd_data  = w_ram_rd_data;
         assign rd_valid = r_rd_valid;
      end
   endgenerate

   assign full         = r_full;
   assign almost_full  = r_afull;
   assign empty        = r_empty;
   assign almost_empty = r_aempty;
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (DEPTH=8); works in both read modes
// (PARAM_SYNC_FIFO_FWFT_EN defined or not).
module tb_param_sync_fifo;
   import param_sync_fifo_pkg::*;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int CW = cnt_w(D);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [W-1:0]  wr_data = '0;
   logic [W-1:0]  rd_data;
   logic          rd_valid, full, almost_full, empty, almost_empty;
   logic [CW-1:0] count;
   logic          overflow, underflow;

   param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .almost_full(almost_full),
      .empty(empty), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] model[$];
   logic [W-1:0] sb[$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = model.size();
      chk({tag, " count"},        32'(count),        32'(n));
      chk({tag, " full"},         32'(full),         32'(n == D));
      chk({tag, " empty"},        32'(empty),        32'(n == 0));
      chk({tag, " almost_full"},  32'(almost_full),  32'(n >= 6));
      chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
      chk({tag, " overflow"},     32'(overflow),     32'(m_ovf));
      chk({tag, " underflow"},    32'(underflow),    32'(m_unf));
   endtask

   // Called at posedge+1; drives one cycle and checks the resulting state.
   task automatic step(input bit we, input logic [W-1:0] wd, input bit re, input string tag);
      bit ra, wa;
      wr_en = we; wr_data = wd; rd_en = re;
      ra = re && (model.size() != 0);
      wa = we && ((model.size() != D) || ra);
      if (we && !wa) m_ovf = 1'b1;
      if (re && model.size() == 0) m_unf = 1'b1;
      if (ra) sb.push_back(model.pop_front());
      if (wa) model.push_back(wd);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
      check_state(tag);
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, " rd_data"},  32'(rd_data),  32'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands out a read word.
   always @(negedge clk) begin
      logic [W-1:0] exp;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      if (!rst && rd_valid && rd_en) begin
`else
      if (!rst && rd_valid) begin
`endif
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL rd_valid: unexpected read word %0h, expected none", rd_data);
         end else begin
            exp = sb.pop_front();
            if (rd_data !== exp) begin
               fails++;
               $display("FAIL rd_data: got %0h, expected %0h", rd_data, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      do_reset("reset");

      // Reset with three queued entries, then a read must underflow.
      step(1'b1, 8'h11, 1'b0, "pre-rst wr");
      step(1'b1, 8'h22, 1'b0, "pre-rst wr");
      step(1'b1, 8'h33, 1'b0, "pre-rst wr");
      chk("pre-rst count", 32'(count), 32'd3);
      do_reset("mid rst");
      step(1'b0, 8'h00, 1'b1, "rd after rst");
      chk("rd after rst underflow", 32'(underflow), 32'd1);
      do_reset("rst2");

      // Fill 0x01..0x08, then one extra write overflows.
      for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, "fill");
      chk("fill full", 32'(full), 32'd1);
      step(1'b1, 8'h09, 1'b0, "overflow wr");
      chk("overflow count", 32'(count), 32'd8);
      chk("overflow flag",  32'(overflow), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, "drain");
      chk("drain empty", 32'(empty), 32'd1);
      step(1'b0, 8'h00, 1'b0, "idle");
      do_reset("rst3");

      // Simultaneous write/read at full: pops 0x11, queues 0xAA last.
      for (int i = 1; i <= 8; i++) step(1'b1, W'(8'h10 + i), 1'b0, "fill2");
      step(1'b1, 8'hAA, 1'b1, "simul full");
      chk("simul full count",    32'(count),    32'd8);
      chk("simul full overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, "drain2");
      step(1'b0, 8'h00, 1'b0, "idle");
      do_reset("rst4");

      // Simultaneous at empty: write taken, read rejected.
      step(1'b1, 8'h55, 1'b1, "simul empty");
      chk("simul empty count",     32'(count),     32'd1);
      chk("simul empty underflow", 32'(underflow), 32'd1);
      step(1'b0, 8'h00, 1'b1, "read 55");
      step(1'b0, 8'h00, 1'b0, "idle");
      do_reset("rst5");

      // Wrap: keep 3 queued while 20 write/read pairs cycle the pointers.
      for (int i = 0; i < 3; i++) step(1'b1, W'(8'hC0 + i), 1'b0, "wrap pre");
      for (int i = 0; i < 20; i++) step(1'b1, W'(8'h30 + i), 1'b1, "wrap");
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "wrap drain");
      step(1'b0, 8'h00, 1'b0, "idle");
      step(1'b0, 8'h00, 1'b0, "idle");

      chk("scoreboard leftover", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
